// File: rtl/pic16c57_pkg.sv
// Shared PIC16C57 definitions: OPTION register bit positions and decode helpers.
`default_nettype none

package pic16c57_pkg;

    localparam int OPT_T0CS   = 5;
    localparam int OPT_T0SE   = 4;
    localparam int OPT_PSA    = 3;
    localparam int OPT_PS_MSB = 2;
    localparam int OPT_PS_LSB = 0;

    typedef struct packed {
        logic       t0cs;
        logic       t0se;
        logic       psa;
        logic [2:0] ps;
    } option_t;

    function automatic option_t decode_option(input logic [5:0] opt);
        option_t o;
        o.t0cs = opt[OPT_T0CS];
        o.t0se = opt[OPT_T0SE];
        o.psa  = opt[OPT_PSA];
        o.ps   = opt[OPT_PS_MSB:OPT_PS_LSB];
        return o;
    endfunction

    // Mask covering the low (ps + extra) bits; extra=1 gives the TMR0 rate, extra=0 the WDT rate.
    function automatic logic [7:0] rate_mask(input logic [2:0] ps, input logic extra);
        logic [3:0] n;
        n = {1'b0, ps} + {3'b000, extra};
        return 8'((9'd1 << n) - 9'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wdt_prescaler_if.sv
// Core-side control and status bundle of the watchdog / TMR0 prescaler.
`default_nettype none

interface wdt_prescaler_if;
    logic       wdt_en;
    logic       sleep;
    logic       clear_WDT;
    logic       clear_prescaler;
    logic [5:0] OPTION_in;
    logic       inst_tick;
    logic       WDT_timeout;
    logic       TMR0_inc;
    logic [7:0] prescaler_out;

    modport master (
        output wdt_en, sleep, clear_WDT, clear_prescaler, OPTION_in, inst_tick,
        input  WDT_timeout, TMR0_inc, prescaler_out
    );

    modport slave (
        input  wdt_en, sleep, clear_WDT, clear_prescaler, OPTION_in, inst_tick,
        output WDT_timeout, TMR0_inc, prescaler_out
    );
endinterface

`default_nettype wire

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin plus rising/falling edge detection.
`default_nettype none

module sync_edge_det (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic async_in,
    output logic      rise,
    output logic      fall
);

    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;

    always_comb begin
        s1_d   = async_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/wdt_prescaler.sv
// Watchdog base counter and shared 8-bit prescaler, assignable to TMR0 or the WDT.
`default_nettype none

module wdt_prescaler
    import pic16c57_pkg::*;
#(
    parameter logic [15:0] WDT_BASE = 16'd18000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         T0CKI,
    wdt_prescaler_if.slave    bus
);

    option_t     opt;
    logic        pin_rise, pin_fall;
    logic        src_event;
    logic        base_wrap, base_tick;
    logic        presc_step, presc_clr;
    logic [7:0]  presc_inc;

    logic [15:0] base_q, base_d;
    logic [7:0]  presc_q, presc_d;
    logic        wdt_timeout_q, wdt_timeout_d;
    logic        tmr0_inc_q, tmr0_inc_d;

    sync_edge_det u_sync_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (T0CKI),
        .rise     (pin_rise),
        .fall     (pin_fall)
    );

    always_comb begin
        opt       = decode_option(bus.OPTION_in);
        src_event = opt.t0cs ? (opt.t0se ? pin_fall : pin_rise)
                             : (bus.inst_tick & ~bus.sleep);

        // The base counter keeps running in sleep so the watchdog can wake the core.
        base_wrap = (base_q == WDT_BASE - 16'd1);
        base_tick = bus.wdt_en & ~bus.clear_WDT & base_wrap;
        if (!bus.wdt_en || bus.clear_WDT || base_wrap) begin
            base_d = 16'd0;
        end else begin
            base_d = base_q + 16'd1;
        end

        presc_inc  = presc_q + 8'd1;
        presc_step = opt.psa ? base_tick : src_event;
        presc_clr  = bus.clear_prescaler | (bus.clear_WDT & opt.psa);
        if (presc_clr) begin
            presc_d = 8'd0;
        end else if (presc_step) begin
            presc_d = presc_inc;
        end else begin
            presc_d = presc_q;
        end

        if (opt.psa) begin
            tmr0_inc_d    = src_event;
            wdt_timeout_d = base_tick & ((presc_inc & rate_mask(opt.ps, 1'b0)) == 8'd0);
        end else begin
            tmr0_inc_d    = src_event & ~bus.clear_prescaler
                          & ((presc_inc & rate_mask(opt.ps, 1'b1)) == 8'd0);
            wdt_timeout_d = base_tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q        <= 16'd0;
            presc_q       <= 8'd0;
            wdt_timeout_q <= 1'b0;
            tmr0_inc_q    <= 1'b0;
        end else begin
            base_q        <= base_d;
            presc_q       <= presc_d;
            wdt_timeout_q <= wdt_timeout_d;
            tmr0_inc_q    <= tmr0_inc_d;
        end
    end

    assign bus.WDT_timeout   = wdt_timeout_q;
    assign bus.TMR0_inc      = tmr0_inc_q;
    assign bus.prescaler_out = presc_q;

endmodule

`default_nettype wire

// File: doc/wdt_prescaler.md
WDT_PRESCALER -- requirements
Module: wdt_prescaler

Interface
REQ-001 SHALL provide parameter WDT_BASE, default 16'd18000, meaning clk cycles per watchdog base tick (≥2).
REQ-002 SHALL provide port clk  input  1  the single system clock; all state on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port wdt_en  input  1  watchdog enable (configuration fuse); 0 = watchdog disabled.
REQ-005 SHALL provide port sleep  input  1  core in SLEEP; instruction clock stopped.
REQ-006 SHALL provide port clear_WDT  input  1  CLRWDT/SLEEP strobe from the core, one cycle.
REQ-007 SHALL provide port clear_prescaler  input  1  prescaler-clear strobe from the core (TMR0 write), one cycle.
REQ-008 SHALL provide port OPTION_in  input  6  OPTION register: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS.
REQ-009 SHALL provide port inst_tick  input  1  instruction-cycle strobe (Fosc/4), one cycle wide.
REQ-010 SHALL provide port T0CKI  input  1  external timer pin, asynchronous to clk.
REQ-011 SHALL provide port WDT_timeout  output  1  registered one-cycle watchdog timeout/wake pulse.
REQ-012 SHALL provide port TMR0_inc  output  1  registered one-cycle TMR0 increment pulse.
REQ-013 SHALL provide port prescaler_out  output  8  current prescaler count, for observability.

Function
REQ-014 T0CKI SHALL pass a 2-flop synchronizer plus a previous-value flop; T0SE=0 selects rising edge, T0SE=1 falling edge.
REQ-015 TMR0 source event SHALL be inst_tick & ~sleep when T0CS=0, else the selected synchronized edge.
REQ-016 Base counter SHALL count 0..WDT_BASE-1 every clk while wdt_en=1, wrap to 0, and emit a base tick on wrap; it SHALL run during sleep.
REQ-017 wdt_en=0 SHALL hold the base counter at 0 and force WDT_timeout=0.
REQ-018 PSA=0: 8-bit prescaler SHALL increment on each TMR0 source event; TMR0_inc SHALL pulse when the low PS+1 bits of the incremented value are all 0 (rate 1:2^(PS+1)); WDT_timeout SHALL pulse on each base tick.
REQ-019 PSA=1: TMR0_inc SHALL pulse for every source event (1:1); prescaler SHALL increment on each base tick; WDT_timeout SHALL pulse when the low PS bits of the incremented value are all 0 (PS=0: every base tick; rate 1:2^PS).
REQ-020 Prescaler SHALL wrap 8'hFF→8'h00 silently.
REQ-021 Outputs SHALL lag the causing event by exactly one clk; TMR0_inc via T0CKI SHALL appear 3 clks after the pin level is first sampled.
REQ-022 clear_WDT SHALL zero the base counter and, when PSA=1, the prescaler; the clear overrides any same-cycle increment and suppresses that cycle's WDT_timeout.
REQ-023 clear_prescaler SHALL zero the prescaler, overriding a same-cycle increment; TMR0_inc from that event is suppressed when PSA=0.
REQ-024 Changing PSA or PS SHALL NOT clear the prescaler; the new selection applies from the next clk.
REQ-025 WDT_timeout during sleep SHALL be the same single pulse (core treats it as wake-up).

Reset
REQ-026 rst_n=0 SHALL asynchronously clear base counter, prescaler, synchronizer and edge flops, WDT_timeout, TMR0_inc; prescaler_out=8'h00.
REQ-027 Pin high at reset release SHALL yield one rising edge after synchronization (documented behaviour).

Structure
REQ-028 OPTION bit indices (T0CS=5, T0SE=4, PSA=3, PS=2:0) SHALL be constants in shared package pic16c57_pkg.
REQ-029 Synchronizer and edge detector SHALL be sub-module sync_edge_det.

Verification (WDT_BASE=16)
REQ-030 PSA=0, T0CS=0, PS=001, inst_tick every clk -> TMR0_inc every 4th clk; WDT_timeout every 16 clks.
REQ-031 PSA=1, PS=010, wdt_en=1 -> WDT_timeout every 64 clks; TMR0_inc every clk following inst_tick.
REQ-032 PSA=1, PS=010, clear_WDT at cycle 50 -> no timeout until cycle 114; prescaler_out=0 at 51.
REQ-033 T0CS=1, T0SE=1, PSA=1, T0CKI toggled every 4 clks -> one TMR0_inc 3 clks after each falling edge, none on rising.
REQ-034 sleep=1, T0CS=0 -> no TMR0_inc despite inst_tick; WDT_timeout continues every 16 clks; wdt_en=0 -> no timeout in 1000 clks.
REQ-035 rst_n pulsed low mid-count -> all outputs 0 immediately; counting restarts from 0.
